// File: rtl/rr_mux_nto1.sv
// rr_mux_nto1: N-to-1 round-robin stream mux with registered output; optional RR_MUX_PACKET_LOCK_EN holds the grant until a packet's last beat
module rr_mux_nto1 #(
  parameter int WIDTH = 3,
  parameter int N = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
`ifdef RR_MUX_PACKET_LOCK_EN
  input  logic [N-1:0]         in_last,
  output logic                 out_last,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel
);
  logic [SEL_W-1:0] r_ptr, r_sel, w_gnt, w_idx, w_nptr;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, w_found, w_load, w_xfer, w_last;
`ifdef RR_MUX_PACKET_LOCK_EN
  logic             r_lock, r_last;
  logic [SEL_W-1:0] r_lock_ch;
  assign w_last   = in_last[w_gnt];
  assign out_last = r_last;
`else
  assign w_last = 1'b1;
`endif
  // first valid channel at or after the pointer wins; an open packet pins the grant
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = SEL_W'((int'(r_ptr) + i) % N);
      if (!w_found && in_valid[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
`ifdef RR_MUX_PACKET_LOCK_EN
    if (r_lock) begin
      w_found = in_valid[r_lock_ch];
      w_gnt   = r_lock_ch;
    end
`endif
  end
  assign w_load    = !r_valid || out_ready;
  assign w_xfer    = !rst && w_found && w_load;
  assign in_ready  = w_xfer ? N'(1) << w_gnt : '0;
  assign w_nptr    = (w_gnt == SEL_W'(N - 1)) ? '0 : w_gnt + 1'b1;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sel   = r_sel;
  // output register and pointer advance on each accepted beat; drain clears valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
`ifdef RR_MUX_PACKET_LOCK_EN
      r_lock    <= 1'b0;
      r_last    <= 1'b0;
      r_lock_ch <= '0;
`endif
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= in_data[int'(w_gnt)*WIDTH +: WIDTH];
      r_sel   <= w_gnt;
      if (w_last) r_ptr <= w_nptr;
`ifdef RR_MUX_PACKET_LOCK_EN
      r_lock    <= !w_last;
      r_last    <= w_last;
      r_lock_ch <= w_gnt;
`endif
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_nto1.sv
// tb_rr_mux_nto1: vector table, hand sequences and randomized traffic against a queue-free behavioural model
module tb_rr_mux_nto1;
  localparam int N = 4;
  localparam int W = 3;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_ready;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]  in_last = '1;
  logic          out_last_s;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  int checks = 0;
  int failures = 0;
  int m_ptr = 0, m_sel = 0, m_data = 0, m_lch = 0;
  bit m_ov = 0, m_lock = 0, m_last = 0;
  logic [N-1:0] seen_rdy;

  always #5 clk = ~clk;

  rr_mux_nto1 #(.WIDTH(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef RR_MUX_PACKET_LOCK_EN
    .in_last(in_last), .out_last(out_last_s),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
  );
`ifndef RR_MUX_PACKET_LOCK_EN
  assign out_last_s = 1'b1;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: drive inputs, check combinational ready, clock, update model, check registers
  task automatic apply(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic ord, input logic [N-1:0] lst);
    int g;
    bit found, lock_en, last;
    logic [N-1:0] exp_rdy;
    rst = r; in_valid = v; in_data = d; out_ready = ord; in_last = lst;
`ifdef RR_MUX_PACKET_LOCK_EN
    lock_en = 1;
`else
    lock_en = 0;
`endif
    #1;
    found = 0; g = 0;
    if (m_lock) begin
      found = v[m_lch]; g = m_lch;
    end else begin
      for (int i = 0; i < N; i++)
        if (!found && v[(m_ptr + i) % N]) begin found = 1; g = (m_ptr + i) % N; end
    end
    exp_rdy = (!r && found && (!m_ov || ord)) ? N'(1) << g : '0;
    seen_rdy = in_ready;
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    @(posedge clk); #1;
    last = lock_en ? lst[g] : 1'b1;
    if (r) begin
      m_ov = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_lock = 0; m_last = 0;
    end else if (exp_rdy != 0) begin
      m_ov = 1; m_data = int'(d[g*W +: W]); m_sel = g;
      if (last) m_ptr = (g + 1) % N;
      m_lock = lock_en && !last; m_lch = g; m_last = last;
    end else if (ord) m_ov = 0;
    chk("out_valid", int'(out_valid), int'(m_ov));
    chk("out_data", int'(out_data), m_data);
    chk("out_sel", int'(out_sel), m_sel);
    if (lock_en) chk("out_last", int'(out_last_s), int'(m_last));
  endtask

  typedef struct {
    logic r; logic [N-1:0] v; logic ord;
    logic [N-1:0] rdy; logic ov; logic [W-1:0] od; logic [1:0] os;
  } vec_t;

  localparam logic [N*W-1:0] D = 12'b110_101_011_010;

  initial begin
    vec_t tbl[17];
    logic [N-1:0] cv, cl, acc;
    logic [N*W-1:0] cd;
    tbl = '{
      '{1, 4'hF, 1, 4'b0000, 0, 3'b000, 0},
      '{0, 4'hF, 1, 4'b0001, 1, 3'b010, 0},
      '{0, 4'hF, 1, 4'b0010, 1, 3'b011, 1},
      '{0, 4'hF, 1, 4'b0100, 1, 3'b101, 2},
      '{0, 4'hF, 1, 4'b1000, 1, 3'b110, 3},
      '{0, 4'hF, 1, 4'b0001, 1, 3'b010, 0},
      '{0, 4'h4, 1, 4'b0100, 1, 3'b101, 2},
      '{0, 4'h4, 1, 4'b0100, 1, 3'b101, 2},
      '{0, 4'h0, 1, 4'b0000, 0, 3'b101, 2},
      '{0, 4'hF, 0, 4'b1000, 1, 3'b110, 3},
      '{0, 4'hF, 0, 4'b0000, 1, 3'b110, 3},
      '{0, 4'hF, 0, 4'b0000, 1, 3'b110, 3},
      '{0, 4'hF, 0, 4'b0000, 1, 3'b110, 3},
      '{0, 4'hF, 1, 4'b0001, 1, 3'b010, 0},
      '{0, 4'hF, 0, 4'b0000, 1, 3'b010, 0},
      '{1, 4'hF, 0, 4'b0000, 0, 3'b000, 0},
      '{0, 4'hF, 1, 4'b0001, 1, 3'b010, 0}
    };
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].r, tbl[i].v, D, tbl[i].ord, '1);
      chk($sformatf("tbl%0d_ready", i), int'(seen_rdy), int'(tbl[i].rdy));
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].ov));
      chk($sformatf("tbl%0d_data", i), int'(out_data), int'(tbl[i].od));
      chk($sformatf("tbl%0d_sel", i), int'(out_sel), int'(tbl[i].os));
    end
`ifdef RR_MUX_PACKET_LOCK_EN
    apply(1, 4'h0, D, 1, '1);
    apply(0, 4'h1, D, 1, '1);
    apply(0, 4'h7, D, 1, 4'b0101);
    chk("lock_sel1", int'(out_sel), 1); chk("lock_last1", int'(out_last_s), 0);
    apply(0, 4'h7, D, 1, 4'b0101);
    chk("lock_sel2", int'(out_sel), 1); chk("lock_last2", int'(out_last_s), 0);
    apply(0, 4'h7, D, 1, 4'b0111);
    chk("lock_sel3", int'(out_sel), 1); chk("lock_last3", int'(out_last_s), 1);
    apply(0, 4'h7, D, 1, 4'b0111);
    chk("lock_sel4", int'(out_sel), 2); chk("lock_last4", int'(out_last_s), 1);
`endif
    cv = '0; cd = '0; cl = '1;
    for (int c = 0; c < 3000; c++) begin
      logic r;
      r = ($urandom_range(0, 99) == 0);
      apply(r, cv, cd, logic'($urandom_range(0, 3) != 0), cl);
      acc = seen_rdy & cv;
      for (int k = 0; k < N; k++)
        if (!cv[k] || acc[k] || r) begin
          cv[k] = ($urandom_range(0, 2) != 0);
          cd[k*W +: W] = W'($urandom);
          cl[k] = ($urandom_range(0, 2) == 0);
        end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_mux_nto1.md
Name: rr_mux_nto1

Overview:
Parametrised N-to-1 multiplexer with per-channel valid/ready handshakes, round-robin arbitration and a registered output stage. It is the sequential successor of the team's combinational 4:1 selectors. The select lines are replaced by an internal fair arbiter, so any number of producer channels can share one consumer. It sits between several stream producers and a single downstream sink.

Parameters:
WIDTH, 3, data bits per channel.
N, 4, number of input channels (>=2).
SEL_W, $clog2(N), width of channel index (localparam, derived).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  N  per-channel data valid; bit k belongs to channel k.
in_ready  output  N  per-channel accept; combinational, at most one bit high.
in_data  input  N*WIDTH  flattened channel data; channel k at [k*WIDTH +: WIDTH].
out_valid  output  1  output register holds a beat.
out_ready  input  1  sink accepts the beat.
out_data  output  WIDTH  registered selected data.
out_sel  output  SEL_W  index of the channel that supplied out_data.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. It is sampled only on the rising clk edge.
- Reset state: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready=0 while rst=1.
- Load enable: load = !out_valid || out_ready. This gives full throughput of one beat per cycle under continuous out_ready.
- Arbitration:
  - Search channels ptr, ptr+1, ..., ptr+N-1 (mod N) and pick the first with in_valid=1 as grant g.
  - in_ready[g] = load. All other in_ready bits are 0.
  - No valid channel means in_ready is all zero.
- Transfer (in_valid[g] && in_ready[g]) on edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
  - ptr <= (g+1) mod N, wrapping from N-1 to 0.
- Output: if out_valid && out_ready and there is no new transfer, out_valid <= 0. out_data and out_sel hold their last value.
- Stall: out_valid=1 && out_ready=0 means load=0, so in_ready is all zero. out_data, out_sel and ptr must stay stable.
- Latency: one cycle from input acceptance to out_valid.
- ptr changes only on a transfer. Channels that are idle or not granted never move it.
- Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
- Simultaneous output drain and new load: both happen in the same cycle and out_valid stays 1.
- Reset mid-operation: any held beat is discarded, ptr returns to 0, and in_ready drops in that same cycle.
- Producers must hold in_data and in_valid until accepted. The block does not latch un-granted inputs.

Optional Feature:
Macro RR_MUX_PACKET_LOCK_EN.
- When defined: adds ports in_last (input, N) and out_last (output, 1; reset 0, registered alongside out_data).
  - After a transfer from channel g with in_last[g]=0, the arbiter locks to g. It grants only g, ignoring other valids, until a transfer with in_last[g]=1.
  - ptr advances to g+1 only on that last beat.
  - Reset clears the lock.
- When undefined: the in_last and out_last ports do not exist, and arbitration is per beat as described above.

Test Plan:
- Reset: assert rst with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0, out_sel=0. The first grant after release goes to channel 0.
- Round robin: in_data = {3'b110, 3'b101, 3'b011, 3'b010} (ch3..ch0), all valid, out_ready=1 -> out_data sequence 010, 011, 101, 110, 010, with out_sel 0, 1, 2, 3, 0, one beat per cycle.
- Sparse: only ch2 valid (3'b101) with ptr=3 -> search wraps, ch2 granted, out_sel=2, and ptr becomes 3.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data and out_sel stable. Dropping the stall resumes with the next channel in rotation, with no beat lost or duplicated.
- Mid-reset: rst during a stall with out_valid=1 -> next cycle out_valid=0 and ptr=0. The beat is dropped.
- Lock (macro on): ch1 sends 3 beats with in_last=0,0,1 while ch0 and ch2 are valid -> out_sel=1,1,1, then out_sel=2. out_last=1 only on the third beat.
